// File: rtl/trail_push_arbiter.sv
// trail_push_arbiter
//
// Feeds the trail manager's single push port, one entry per cycle. Decisions
// arrive on a ready/valid port and are pushed in the handshake cycle.
// Implications are buffered in a small FIFO. The FIFO head is checked against
// the live trail through the trail's combinational query port before it is
// pushed. If the head is already assigned with the same value, it is dropped
// and counted as a duplicate. If it is assigned with the opposite value, the
// block raises a conflict and stops pushing until flush.
//
// Ports
//   clk, reset_n            clock, synchronous active-low reset
//   imp_*                   implication stream in (valid/ready, var, value, reason)
//   dec_*                   decision stream in (valid/ready, var, value)
//   push, push_*            trail push strobe and payload (all zero when idle)
//   trail_height            current trail occupancy
//   current_level           current decision level of the trail
//   query_var               FIFO head variable (0 when empty), registered
//   query_valid/query_value trail answer for query_var
//   backtrack_busy          freezes head evaluation and decisions
//   flush                   empties the FIFO and clears the conflict state
//   conflict, conflict_*    conflict state and the rejected implication
//   fifo_count, dup_count   FIFO occupancy, saturating duplicate counter
module trail_push_arbiter #(
  parameter int MAX_VARS   = 256,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            imp_valid,
  output logic                            imp_ready,
  input  logic [31:0]                     imp_var,
  input  logic                            imp_value,
  input  logic [15:0]                     imp_reason,
  input  logic                            dec_valid,
  output logic                            dec_ready,
  input  logic [31:0]                     dec_var,
  input  logic                            dec_value,
  output logic                            push,
  output logic [31:0]                     push_var,
  output logic                            push_value,
  output logic [15:0]                     push_level,
  output logic                            push_is_decision,
  output logic [15:0]                     push_reason,
  input  logic [15:0]                     trail_height,
  input  logic [15:0]                     current_level,
  output logic [31:0]                     query_var,
  input  logic                            query_valid,
  input  logic                            query_value,
  input  logic                            backtrack_busy,
  input  logic                            flush,
  output logic                            conflict,
  output logic [31:0]                     conflict_var,
  output logic [15:0]                     conflict_reason,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_count,
  output logic [15:0]                     dup_count
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [31:0]   MAX_C   = 32'(MAX_VARS);

  typedef enum logic {S_RUN, S_CONFLICT} state_t;

  typedef struct packed {
    logic [31:0] vid;
    logic        value;
    logic [15:0] reason;
  } entry_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  state_t        state;
  entry_t        fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;

  entry_t head;
  logic   trail_room;
  logic   run_ok;
  logic   eval;
  logic   imp_push;
  logic   dup_hit;
  logic   contra;
  logic   pop;
  logic   enq;
  logic   dec_fire;

  // Stage 0: registered FIFO head and control, feeding the trail query
  assign head       = fifo_mem[rd_ptr];
  assign query_var  = (count != '0) ? head.vid : 32'd0;
  assign fifo_count = count;
  assign conflict   = (state == S_CONFLICT);

  // Decode of the current head against the trail answer
  assign trail_room = ({16'd0, trail_height} < MAX_C);
  // reset_n gating keeps both ready outputs low while reset is held
  assign run_ok     = reset_n & (state == S_RUN) & !flush;
  assign eval       = run_ok & !backtrack_busy & (count != '0) & trail_room;
  assign imp_push   = eval & !query_valid;
  assign dup_hit    = eval & query_valid & (query_value == head.value);
  assign contra     = eval & query_valid & (query_value != head.value);
  assign pop        = imp_push | dup_hit;

  // imp_ready uses the registered count, so a pop and an enqueue at full
  // never coincide.
  assign imp_ready  = run_ok & (count < DEPTH_C);
  assign enq        = imp_valid & imp_ready;

  assign dec_ready  = run_ok & !backtrack_busy & (count == '0) & trail_room;
  assign dec_fire   = dec_valid & dec_ready;

  // Push mux: an implication push needs count>0, a decision needs count==0,
  // so the two sources are mutually exclusive.
  always_comb begin
    push             = 1'b0;
    push_var         = 32'd0;
    push_value       = 1'b0;
    push_level       = 16'd0;
    push_is_decision = 1'b0;
    push_reason      = 16'd0;
    if (imp_push) begin
      push        = 1'b1;
      push_var    = head.vid;
      push_value  = head.value;
      push_level  = current_level;
      push_reason = head.reason;
    end else if (dec_fire) begin
      push             = 1'b1;
      push_var         = dec_var;
      push_value       = dec_value;
      push_level       = current_level + 16'd1;
      push_is_decision = 1'b1;
      push_reason      = 16'hFFFF;
    end
  end

  // Stage 1: FIFO storage (data only, no reset)
  always_ff @(posedge clk) begin
    if (enq) begin
      fifo_mem[wr_ptr] <= '{vid: imp_var, value: imp_value, reason: imp_reason};
    end
  end

  // Stage 1: control state, pointers and counters
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state           <= S_RUN;
      rd_ptr          <= '0;
      wr_ptr          <= '0;
      count           <= '0;
      dup_count       <= 16'd0;
      conflict_var    <= 32'd0;
      conflict_reason <= 16'd0;
    end else if (flush) begin
      // conflict_var/conflict_reason keep their last values for inspection
      state  <= S_RUN;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + PW'(1);
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(enq) - CW'(pop);
      if (dup_hit) dup_count <= sat_inc16(dup_count);
      if (contra) begin
        state           <= S_CONFLICT;
        conflict_var    <= head.vid;
        conflict_reason <= head.reason;
      end
    end
  end

endmodule

// File: tb/tb_trail_push_arbiter.sv
module tb_trail_push_arbiter;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        imp_valid = 1'b0;
  logic        imp_ready;
  logic [31:0] imp_var = 32'd0;
  logic        imp_value = 1'b0;
  logic [15:0] imp_reason = 16'd0;
  logic        dec_valid = 1'b0;
  logic        dec_ready;
  logic [31:0] dec_var = 32'd0;
  logic        dec_value = 1'b0;
  logic        push;
  logic [31:0] push_var;
  logic        push_value;
  logic [15:0] push_level;
  logic        push_is_decision;
  logic [15:0] push_reason;
  logic [15:0] trail_height = 16'd10;
  logic [15:0] current_level = 16'd3;
  logic [31:0] query_var;
  logic        query_valid;
  logic        query_value;
  logic        backtrack_busy = 1'b0;
  logic        flush = 1'b0;
  logic        conflict;
  logic [31:0] conflict_var;
  logic [15:0] conflict_reason;
  logic [4:0]  fifo_count;
  logic [15:0] dup_count;

  trail_push_arbiter #(.MAX_VARS(256), .FIFO_DEPTH(16)) dut (
    .clk(clk), .reset_n(reset_n),
    .imp_valid(imp_valid), .imp_ready(imp_ready), .imp_var(imp_var),
    .imp_value(imp_value), .imp_reason(imp_reason),
    .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_var(dec_var),
    .dec_value(dec_value),
    .push(push), .push_var(push_var), .push_value(push_value),
    .push_level(push_level), .push_is_decision(push_is_decision),
    .push_reason(push_reason),
    .trail_height(trail_height), .current_level(current_level),
    .query_var(query_var), .query_valid(query_valid), .query_value(query_value),
    .backtrack_busy(backtrack_busy), .flush(flush),
    .conflict(conflict), .conflict_var(conflict_var),
    .conflict_reason(conflict_reason),
    .fifo_count(fifo_count), .dup_count(dup_count)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int acc_cyc = 0;

  logic [79:0] exp_q[$];
  int          push_cyc[$];

  // Trail model: variables 0..63, assigned flag and value
  logic [63:0] tv = '0;
  logic [63:0] tval = '0;
  logic        pend_vld = 1'b0;
  logic [5:0]  pend_var = 6'd0;
  logic        pend_val = 1'b0;

  assign query_valid = (query_var < 32'd64) ? tv[query_var[5:0]] : 1'b0;
  assign query_value = (query_var < 32'd64) ? tval[query_var[5:0]] : 1'b0;

  task automatic chk(input string tag, input logic [79:0] got, input logic [79:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (pend_vld) begin
      tv[pend_var]   <= 1'b1;
      tval[pend_var] <= pend_val;
    end
  end

  // Push monitor: the trail registers the push at the next edge
  always @(negedge clk) begin
    logic [79:0] got;
    logic [79:0] e;
    got = {14'd0, push_var, push_value, push_level, push_is_decision, push_reason};
    pend_vld <= push;
    pend_var <= push_var[5:0];
    pend_val <= push_value;
    if (push) begin
      push_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        chk("unexpected_push", 80'(exp_q.size()), 80'd1);
      end else begin
        e = exp_q.pop_front();
        chk("push", got, e);
      end
    end else begin
      chk("push_zero", got, 80'd0);
    end
  end

  function automatic logic [79:0] mk_exp(input int v, input bit val, input logic [15:0] lvl,
                                          input bit isdec, input logic [15:0] r);
    return {14'd0, v[31:0], val, lvl, isdec, r};
  endfunction

  task automatic send_imp(input int v, input bit val, input int r, input bit exp_push);
    bit got;
    got = 1'b0;
    imp_valid  = 1'b1;
    imp_var    = v[31:0];
    imp_value  = val;
    imp_reason = r[15:0];
    for (int n = 0; n < 200 && !got; n++) begin
      @(negedge clk);
      got = imp_ready;
      if (!got) @(posedge clk);
    end
    if (!got) begin
      chk("imp_timeout", 80'd0, 80'd1);
      imp_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    acc_cyc   = cyc;
    imp_valid = 1'b0;
    if (exp_push) exp_q.push_back(mk_exp(v, val, current_level, 1'b0, 16'(r)));
  endtask

  task automatic wait_drain();
    bit done;
    done = 1'b0;
    for (int n = 0; n < 300 && !done; n++) begin
      @(negedge clk);
      done = (exp_q.size() == 0) && (fifo_count == 5'd0);
    end
    if (!done) chk("drain_timeout", 80'd0, 80'd1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int a0;
    bit got;
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0;
    bit got;
    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_push", 80'(push), 80'd0);
    chk("rst_conflict", 80'(conflict), 80'd0);
    chk("rst_count", 80'(fifo_count), 80'd0);
    chk("rst_dup", 80'(dup_count), 80'd0);
    chk("rst_cvar", 80'(conflict_var), 80'd0);
    chk("rst_creason", 80'(conflict_reason), 80'd0);
    chk("rst_imp_ready", 80'(imp_ready), 80'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(negedge clk);
    chk("imp_ready_rise", 80'(imp_ready), 80'd1);
    @(posedge clk);
    #1;

    // Three back-to-back implications, unassigned
    push_cyc.delete();
    send_imp(5, 1'b1, 2, 1'b1);
    a0 = acc_cyc;
    send_imp(6, 1'b0, 3, 1'b1);
    send_imp(7, 1'b1, 4, 1'b1);
    wait_drain();
    chk("n_pushes", 80'(push_cyc.size()), 80'd3);
    if (push_cyc.size() == 3) begin
      chk("lat0", 80'(push_cyc[0]), 80'(a0));
      chk("lat1", 80'(push_cyc[1]), 80'(a0 + 1));
      chk("lat2", 80'(push_cyc[2]), 80'(a0 + 2));
    end

    // Decision waits for the FIFO to drain
    send_imp(10, 1'b1, 5, 1'b1);
    dec_valid = 1'b1;
    dec_var   = 32'd9;
    dec_value = 1'b1;
    exp_q.push_back(mk_exp(9, 1'b1, current_level + 16'd1, 1'b1, 16'hFFFF));
    @(negedge clk);
    chk("dec_ready_blocked", 80'(dec_ready), 80'd0);
    got = 1'b0;
    for (int n = 0; n < 50 && !got; n++) begin
      @(posedge clk);
      @(negedge clk);
      got = dec_ready;
    end
    chk("dec_ready_after", 80'(got), 80'd1);
    @(posedge clk);
    #1;
    dec_valid = 1'b0;
    wait_drain();

    // Duplicate: var 5=1 already on the trail
    send_imp(5, 1'b1, 9, 1'b0);
    wait_drain();
    chk("dup_count", 80'(dup_count), 80'd1);

    // Contradiction: var 5=0 while trail holds 5=1
    send_imp(5, 1'b0, 7, 1'b0);
    repeat (2) @(negedge clk);
    chk("conflict", 80'(conflict), 80'd1);
    chk("conflict_var", 80'(conflict_var), 80'd5);
    chk("conflict_reason", 80'(conflict_reason), 80'd7);
    chk("conf_imp_ready", 80'(imp_ready), 80'd0);
    chk("conf_count", 80'(fifo_count), 80'd1);
    chk("conf_dec_ready", 80'(dec_ready), 80'd0);
    @(posedge clk);
    #1;
    flush = 1'b1;
    @(negedge clk);
    chk("flush_imp_ready", 80'(imp_ready), 80'd0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    @(negedge clk);
    chk("flush_count", 80'(fifo_count), 80'd0);
    chk("flush_conflict", 80'(conflict), 80'd0);
    chk("flush_cvar_hold", 80'(conflict_var), 80'd5);
    @(posedge clk);
    #1;

    // Trail full: stall without drop or conflict
    trail_height = 16'd256;
    send_imp(60, 1'b1, 11, 1'b1);
    repeat (3) @(negedge clk);
    chk("full_count", 80'(fifo_count), 80'd1);
    chk("full_conflict", 80'(conflict), 80'd0);
    chk("full_dec_ready", 80'(dec_ready), 80'd0);
    @(posedge clk);
    #1;
    trail_height = 16'd10;
    wait_drain();

    // Fill under backtrack_busy, then drain
    backtrack_busy = 1'b1;
    for (int i = 0; i < 16; i++) send_imp(20 + i, i[0], 100 + i, 1'b1);
    @(negedge clk);
    chk("fill_imp_ready", 80'(imp_ready), 80'd0);
    chk("fill_count", 80'(fifo_count), 80'd16);
    chk("fill_dec_ready", 80'(dec_ready), 80'd0);
    @(posedge clk);
    #1;
    backtrack_busy = 1'b0;
    wait_drain();

    // Offset pointers, then refill so the ring wraps
    for (int i = 0; i < 5; i++) send_imp(36 + i, 1'b1, 200 + i, 1'b1);
    wait_drain();
    backtrack_busy = 1'b1;
    for (int i = 0; i < 16; i++) send_imp(41 + i, ~i[0], 300 + i, 1'b1);
    @(negedge clk);
    chk("wrap_count", 80'(fifo_count), 80'd16);
    chk("wrap_imp_ready", 80'(imp_ready), 80'd0);
    @(posedge clk);
    #1;
    backtrack_busy = 1'b0;
    wait_drain();

    // Reset mid-operation discards buffered entries
    backtrack_busy = 1'b1;
    for (int i = 0; i < 5; i++) send_imp(57 + i, 1'b1, 400 + i, 1'b0);
    @(negedge clk);
    chk("pre_rst_count", 80'(fifo_count), 80'd5);
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(negedge clk);
    chk("mid_rst_count", 80'(fifo_count), 80'd0);
    chk("mid_rst_push", 80'(push), 80'd0);
    chk("mid_rst_dup", 80'(dup_count), 80'd0);
    @(posedge clk);
    #1;
    backtrack_busy = 1'b0;
    repeat (5) @(negedge clk);
    chk("final_queue", 80'(exp_q.size()), 80'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
